// File: rtl/morse_encoder.sv
// morse_encoder: letter code to on/off keying serialiser.
// Feeds the Morse decoder; letter codes match its output.
module morse_encoder #(
  parameter int UNIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] letter_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       out,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(3 * UNIT) + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MARK = 3'd1;
  localparam logic [2:0] EGAP = 3'd2;
  localparam logic [2:0] LGAP = 3'd3;
  localparam logic [2:0] WGAP = 3'd4;

  // The IDLE cycle is the last silent cycle of a letter or
  // word gap, so back-to-back codes get exact 3/7 unit gaps.
  localparam logic [CW-1:0] D_DOT = CW'(UNIT - 1);
  localparam logic [CW-1:0] D_DSH = CW'(3 * UNIT - 1);
  localparam logic [CW-1:0] D_LG  = CW'(3 * UNIT - 2);
  localparam logic [CW-1:0] D_WG  = CW'(4 * UNIT - 2);

  logic [2:0]    state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [3:0]    pat, npat;
  logic [1:0]    rem, nrem;
  logic          nerr;
  logic [6:0]    ent;

  // {len[2:0], pattern[3:0]} with the pattern left-aligned
  function automatic logic [6:0] rom(input logic [4:0] c);
    logic [6:0] r;
    case (c)
      5'd0:    r = {3'd2, 4'b0100};
      5'd1:    r = {3'd4, 4'b1000};
      5'd2:    r = {3'd4, 4'b1010};
      5'd3:    r = {3'd3, 4'b1000};
      5'd4:    r = {3'd1, 4'b0000};
      5'd5:    r = {3'd4, 4'b0010};
      5'd6:    r = {3'd3, 4'b1100};
      5'd7:    r = {3'd4, 4'b0000};
      5'd8:    r = {3'd2, 4'b0000};
      5'd9:    r = {3'd4, 4'b0111};
      5'd10:   r = {3'd3, 4'b1010};
      5'd11:   r = {3'd4, 4'b0100};
      5'd12:   r = {3'd2, 4'b1100};
      5'd13:   r = {3'd2, 4'b1000};
      5'd14:   r = {3'd3, 4'b1110};
      5'd15:   r = {3'd4, 4'b0110};
      5'd16:   r = {3'd4, 4'b1101};
      5'd17:   r = {3'd3, 4'b0100};
      5'd18:   r = {3'd3, 4'b0000};
      5'd19:   r = {3'd1, 4'b1000};
      5'd20:   r = {3'd3, 4'b0010};
      5'd21:   r = {3'd4, 4'b0001};
      5'd22:   r = {3'd3, 4'b0110};
      5'd23:   r = {3'd4, 4'b1001};
      5'd24:   r = {3'd4, 4'b1011};
      5'd25:   r = {3'd4, 4'b1100};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

  assign ready_out = (state == IDLE);
  assign ent       = rom(letter_in);

  // next-state, duration counter and element sequencing
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    npat   = pat;
    nrem   = rem;
    nerr   = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          if (letter_in == 5'd31) begin
            nstate = WGAP;
            ncnt   = D_WG;
          end else if (letter_in <= 5'd25) begin
            nstate = MARK;
            npat   = ent[3:0];
            nrem   = 2'(ent[6:4] - 3'd1);
            ncnt   = ent[3] ? D_DSH : D_DOT;
          end else begin
            nerr   = 1'b1;
          end
        end
      end
      MARK: begin
        if (cnt != '0) begin
          ncnt = cnt - 1'b1;
        end else if (rem != 2'd0) begin
          nstate = EGAP;
          ncnt   = D_DOT;
          npat   = {pat[2:0], 1'b0};
          nrem   = rem - 2'd1;
        end else begin
          nstate = LGAP;
          ncnt   = D_LG;
        end
      end
      EGAP: begin
        if (cnt != '0) begin
          ncnt = cnt - 1'b1;
        end else begin
          nstate = MARK;
          ncnt   = pat[3] ? D_DSH : D_DOT;
        end
      end
      LGAP, WGAP: begin
        if (cnt != '0) begin
          ncnt = cnt - 1'b1;
        end else begin
          nstate = IDLE;
        end
      end
      default: begin
        nstate = IDLE;
        ncnt   = '0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pat   <= '0;
      rem   <= '0;
      out   <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      pat   <= npat;
      rem   <= nrem;
      out   <= (nstate == MARK);
      busy  <= (nstate != IDLE);
      err   <= nerr;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: directed checks of keying timing,
// word space, invalid codes and reset mid-mark.
module tb_morse_encoder;

  localparam int U = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] letter_in = 5'd0;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       out;
  logic       busy;
  logic       err;

  int total = 0;
  int bad = 0;

  string mt [0:25] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
    "....", "..", ".---", "-.-", ".-..", "--", "-.",
    "---", ".--.", "--.-", ".-.", "...", "-", "..-",
    "...-", ".--", "-..-", "-.--", "--.."
  };

  morse_encoder #(.UNIT(U)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .letter_in(letter_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .out      (out),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [4:0] c);
    int n = 0;
    while (!ready_out && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("acc_wait", 128'(n < 500), 128'(1));
    letter_in = c;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
  endtask

  function automatic int build(input string m,
                               output logic [127:0] v);
    int k = 0;
    v = '0;
    for (int i = 0; i < m.len(); i++) begin
      int d = (m[i] == "-") ? 3 * U : U;
      for (int j = 0; j < d; j++) begin
        v[k] = 1'b1;
        k++;
      end
      if (i < m.len() - 1) k += U;
    end
    return k + 3 * U;
  endfunction

  task automatic run(input string tag, input int len,
                     input logic [127:0] expo);
    logic [127:0] o = '0;
    logic [127:0] r = '0;
    logic [127:0] b = '0;
    logic [127:0] er = '0;
    logic [127:0] eb = '0;
    for (int k = 0; k < len; k++) begin
      o[k] = out;
      r[k] = ready_out;
      b[k] = busy;
      if (k < len - 1) begin
        @(posedge clk);
        #1;
      end
    end
    er[len-1] = 1'b1;
    for (int k = 0; k < len - 1; k++) eb[k] = 1'b1;
    chk({tag, "_out"}, o, expo);
    chk({tag, "_rdy"}, r, er);
    chk({tag, "_busy"}, b, eb);
  endtask

  task automatic send(input string tag, input logic [4:0] c);
    logic [127:0] v;
    int l;
    accept(c);
    l = build(mt[c], v);
    run(tag, l, v);
  endtask

  initial begin
    logic [127:0] acc;
    #12;
    chk("rst_outs", 128'({out, busy, err, ready_out}),
        128'(4'b0001));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // E: 4 high then 12 low, ready at 16th cycle
    accept(5'd4);
    run("E", 16, 128'h0000_000F);

    // A: 1x4 0x4 1x12 0x12
    accept(5'd0);
    run("A", 32, 128'h000F_FF0F);

    // E, word space, E: silence between marks is 12+16=28
    accept(5'd4);
    run("ws_E1", 16, 128'h0000_000F);
    accept(5'd31);
    run("ws_gap", 16, 128'h0);
    accept(5'd4);
    run("ws_E2", 16, 128'h0000_000F);

    // invalid code 27
    letter_in = 5'd27;
    valid_in  = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    chk("inv_pulse", 128'({err, ready_out, out, busy}),
        128'(4'b1100));
    acc = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      acc[k] = err | out | busy | ~ready_out;
    end
    chk("inv_after", acc, 128'h0);

    // T then reset 5 cycles into the dash
    accept(5'd19);
    repeat (4) @(posedge clk);
    #3;
    chk("t_mark", 128'({out, busy}), 128'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 128'({out, busy, err, ready_out}),
        128'(4'b0001));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send("Q", 5'd16);

    // SOS back to back
    send("S1", 5'd18);
    send("O", 5'd14);
    send("S2", 5'd18);

    // whole alphabet back to back
    for (int c = 0; c < 26; c++) begin
      send($sformatf("L%0d", c), 5'(c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
# morse_encoder

Upstream stimulus stage for the Morse decoder. It accepts 5-bit letter codes over a valid/ready handshake and serialises each one into an on/off keying stream on `out`, which drives the decoder's `in` input. It uses the same letter code as the decoder's `letter` output (0 = A … 25 = Z), so a loopback of the two blocks must reproduce the input text.

## Interface
- `UNIT`, default 4: length of one Morse time unit in `clk` cycles; legal range 1..1024.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `letter_in`  input  5  code to send:
  - 0..25 = A..Z.
  - 31 = word space.
  - 26..30 = invalid.
- `valid_in`  input  1  `letter_in` is valid this cycle.
- `ready_out`  output  1  encoder can accept a code. High only in IDLE; combinational from state.
- `out`  output  1  registered serial keying stream; 1 = tone.
- `busy`  output  1  registered; high in any state other than IDLE.
- `err`  output  1  registered; one-cycle pulse when an invalid code is accepted.

## Operation
- The internal ROM holds each letter as a length (1..4) and a pattern, sent MSB-first, where 1 = dash:
  - A .-, B -..., C -.-., D -.., E ., F ..-., G --., H ...., I .., J .---, K -.-, L .-.., M --
  - N -., O ---, P .--., Q --.-, R .-., S ..., T -, U ..-, V ...-, W .--, X -..-, Y -.--, Z --..
- Element durations:
  - dot: mark of 1 unit.
  - dash: mark of 3 units.
  - gap between elements of one letter: 1 unit.
  - gap after the last element: 3 units.
  - word space: 4 extra units of silence, giving 7 units total after the preceding letter gap.
- States:
  - IDLE: `ready_out`=1, `out`=0.
  - MARK: `out`=1.
  - EGAP: inter-element gap.
  - LGAP: letter gap.
  - WGAP: word space.
- A handshake occurs on an edge where `valid_in`=1 and `ready_out`=1:
  - Letter code: latch the length and pattern, go to MARK, set `out`<=1.
  - Code 31: go to WGAP, `out` stays 0.
  - Codes 26..30: stay in IDLE, `err`<=1 for one cycle, nothing is transmitted.
- MARK lasts UNIT cycles for a dot or 3·UNIT for a dash. At the end it goes to EGAP if elements remain, otherwise LGAP.
- EGAP lasts UNIT cycles, then goes to MARK for the next element.
- LGAP lasts 3·UNIT cycles, then goes to IDLE.
- WGAP lasts 4·UNIT cycles, then goes to IDLE.
- `valid_in` while not ready is ignored. The code is not queued; the upstream holds it until ready.
- Duration counter:
  - width is clog2(3·UNIT)+1 bits minimum;
  - loads duration−1 on entry to a state and counts down to 0;
  - there is no wrap-around.
- Reset, asserted at any time including mid-mark:
  - state IDLE, `out`=0, `busy`=0, `err`=0, `ready_out`=1;
  - latched code cleared;
  - after deassertion the block accepts on the first edge.

## Timing
- Accept edge t0 → `out`=1 from t0+1.
  - No dead cycle between handshake and first mark.
- The time from the accept edge to re-entry into IDLE (`ready_out` high again) is (marks + inter-element gaps + 3)·UNIT cycles.
  - E: 4·UNIT.
  - A: 8·UNIT.
  - Word space: 4·UNIT.
- A code accepted on the IDLE-entry edge starts its mark immediately. Back-to-back letters therefore have exactly a 3-unit gap.
- Invalid code: the accept edge raises `err` for exactly one cycle; `ready_out` stays 1 throughout.
- `busy` equals the inverse of `ready_out`, delayed by zero cycles, since both derive from the state register.

## Test plan
- **E, UNIT=4**, `letter_in`=4 accepted at t0:
  - `out` high for exactly 4 cycles, then low for 12;
  - `ready_out` returns at t0+16.
- **A (0), UNIT=4**:
  - `out` pattern 1×4, 0×4, 1×12, 0×12;
  - `ready_out` at t0+32.
- **Word space**: E then 31 then E.
  - Low interval between the two E marks is 28 cycles (7 units).
  - `busy` stays high through WGAP.
- **Invalid code**: `letter_in`=27 held valid for 1 cycle.
  - `err` pulses 1 cycle;
  - `out` stays 0;
  - `ready_out` never drops.
- **Reset mid-dash**: T (19) accepted, `rst_n` pulled low 5 cycles into the mark.
  - `out`=0 immediately (asynchronous);
  - after release, Q (16) is accepted and sent correctly.
- **Loopback**: "SOS" (18,14,18) into the decoder, with UNIT matching the decoder timing.
  - The decoder raises `done` three times with `letter`=18, 14, 18.
